// File: rtl/reorder_buffer_if.sv
// Issue / CDB / retire bundle for the reorder buffer.
// Operand lookup signals exist only when ROB_BYPASS_EN is defined.
interface reorder_buffer_if #(
  parameter int SIZE  = 8,
  parameter int IDX_W = $clog2(SIZE)
);
  logic                       alloc_valid_in;
  logic [4:0]                 alloc_rd_in;
  logic                       alloc_has_rd_in;
  logic                       ready_out;
  logic [IDX_W-1:0]           alloc_idx_out;

  logic                       cdb_valid_in;
  logic [IDX_W-1:0]           cdb_idx_in;
  logic signed [31:0]         cdb_data_in;
  logic                       cdb_mispredict_in;
  logic [31:0]                cdb_target_in;

  logic                       we_out;
  logic [4:0]                 wa_out;
  logic signed [31:0]         wd_out;
  logic [IDX_W-1:0]           wrob_ix_out;
  logic                       flush_out;
  logic [SIZE-1:0][4:0]       flush_addrs_out;
  logic [31:0]                redirect_pc_out;
  logic [IDX_W:0]             count_out;

`ifdef ROB_BYPASS_EN
  logic [IDX_W-1:0]           query_idx1_in;
  logic [IDX_W-1:0]           query_idx2_in;
  logic                       query_ready1_out;
  logic                       query_ready2_out;
  logic signed [31:0]         query_data1_out;
  logic signed [31:0]         query_data2_out;

  modport master (
    output alloc_valid_in, alloc_rd_in, alloc_has_rd_in,
    output cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
    output query_idx1_in, query_idx2_in,
    input  ready_out, alloc_idx_out, we_out, wa_out, wd_out, wrob_ix_out,
    input  flush_out, flush_addrs_out, redirect_pc_out, count_out,
    input  query_ready1_out, query_ready2_out, query_data1_out, query_data2_out
  );

  modport slave (
    input  alloc_valid_in, alloc_rd_in, alloc_has_rd_in,
    input  cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
    input  query_idx1_in, query_idx2_in,
    output ready_out, alloc_idx_out, we_out, wa_out, wd_out, wrob_ix_out,
    output flush_out, flush_addrs_out, redirect_pc_out, count_out,
    output query_ready1_out, query_ready2_out, query_data1_out, query_data2_out
  );
`else
  modport master (
    output alloc_valid_in, alloc_rd_in, alloc_has_rd_in,
    output cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
    input  ready_out, alloc_idx_out, we_out, wa_out, wd_out, wrob_ix_out,
    input  flush_out, flush_addrs_out, redirect_pc_out, count_out
  );

  modport slave (
    input  alloc_valid_in, alloc_rd_in, alloc_has_rd_in,
    input  cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
    output ready_out, alloc_idx_out, we_out, wa_out, wd_out, wrob_ix_out,
    output flush_out, flush_addrs_out, redirect_pc_out, count_out
  );
`endif
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer for the Tomasulo core; squashes everything on a mispredicted head.
// Optional operand lookup ports are enabled by defining ROB_BYPASS_EN.
module reorder_buffer #(
  parameter int SIZE  = 8,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  reorder_buffer_if.slave  rob
);

  logic [SIZE-1:0]        busy_q, busy_d, done_q, done_d;
  logic [SIZE-1:0]        hasRd_q, hasRd_d, misp_q, misp_d;
  logic [4:0]             rd_q     [SIZE];
  logic [4:0]             rd_d     [SIZE];
  logic signed [31:0]     value_q  [SIZE];
  logic signed [31:0]     value_d  [SIZE];
  logic [31:0]            target_q [SIZE];
  logic [31:0]            target_d [SIZE];
  logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]         count_q, count_d;

  logic                   we_q, we_d, flush_q, flush_d;
  logic [4:0]             wa_q, wa_d;
  logic signed [31:0]     wd_q, wd_d;
  logic [IDX_W-1:0]       wrobIx_q, wrobIx_d;
  logic [SIZE-1:0][4:0]   flushAddrs_q, flushAddrs_d;
  logic [31:0]            redirect_q, redirect_d;

  logic commitOk, flushNow, readyInt, allocFire, wbFire;

  // A mispredicted head blocks allocation so nothing is issued into a buffer about to be squashed.
  always_comb begin
    commitOk  = busy_q[head_q] && done_q[head_q];
    flushNow  = commitOk && misp_q[head_q];
    readyInt  = (count_q < (IDX_W+1)'(SIZE)) && !flushNow;
    allocFire = rob.alloc_valid_in && readyInt;
    wbFire    = rob.cdb_valid_in && busy_q[rob.cdb_idx_in];
  end

  always_comb begin
    busy_d       = busy_q;
    done_d       = done_q;
    hasRd_d      = hasRd_q;
    misp_d       = misp_q;
    rd_d         = rd_q;
    value_d      = value_q;
    target_d     = target_q;
    head_d       = head_q;
    tail_d       = tail_q;
    we_d         = 1'b0;
    flush_d      = 1'b0;
    wa_d         = wa_q;
    wd_d         = wd_q;
    wrobIx_d     = wrobIx_q;
    flushAddrs_d = flushAddrs_q;
    redirect_d   = redirect_q;

    if (allocFire) begin
      busy_d[tail_q]  = 1'b1;
      done_d[tail_q]  = 1'b0;
      misp_d[tail_q]  = 1'b0;
      rd_d[tail_q]    = rob.alloc_rd_in;
      hasRd_d[tail_q] = rob.alloc_has_rd_in;
      tail_d          = tail_q + 1'b1;
    end

    if (wbFire) begin
      done_d[rob.cdb_idx_in]   = 1'b1;
      value_d[rob.cdb_idx_in]  = rob.cdb_data_in;
      misp_d[rob.cdb_idx_in]   = rob.cdb_mispredict_in;
      target_d[rob.cdb_idx_in] = rob.cdb_target_in;
    end

    if (commitOk) begin
      we_d           = hasRd_q[head_q] && (rd_q[head_q] != 5'd0);
      wa_d           = rd_q[head_q];
      wd_d           = value_q[head_q];
      wrobIx_d       = head_q;
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    // The head still retires its link value; every younger entry is reported and discarded.
    if (flushNow) begin
      flush_d    = 1'b1;
      redirect_d = target_q[head_q];
      for (int i = 0; i < SIZE; i++) begin
        flushAddrs_d[i] = (IDX_W'(i) != head_q && busy_q[i] && hasRd_q[i]) ? rd_q[i] : 5'd0;
      end
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      count_d = count_q + (IDX_W+1)'(allocFire) - (IDX_W+1)'(commitOk);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      we_q         <= 1'b0;
      flush_q      <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      wrobIx_q     <= '0;
      flushAddrs_q <= '0;
      redirect_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      we_q         <= we_d;
      flush_q      <= flush_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      wrobIx_q     <= wrobIx_d;
      flushAddrs_q <= flushAddrs_d;
      redirect_q   <= redirect_d;
    end
  end

  // Payload fields are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk_in) begin
    hasRd_q  <= hasRd_d;
    misp_q   <= misp_d;
    rd_q     <= rd_d;
    value_q  <= value_d;
    target_q <= target_d;
  end

  assign rob.ready_out       = readyInt;
  assign rob.alloc_idx_out   = tail_q;
  assign rob.we_out          = we_q;
  assign rob.wa_out          = wa_q;
  assign rob.wd_out          = wd_q;
  assign rob.wrob_ix_out     = wrobIx_q;
  assign rob.flush_out       = flush_q;
  assign rob.flush_addrs_out = flushAddrs_q;
  assign rob.redirect_pc_out = redirect_q;
  assign rob.count_out       = count_q;

`ifdef ROB_BYPASS_EN
  // A same-cycle CDB broadcast wins over the stored value so operands are never one cycle stale.
  logic cdbHit1, cdbHit2;
  assign cdbHit1 = rob.cdb_valid_in && (rob.cdb_idx_in == rob.query_idx1_in);
  assign cdbHit2 = rob.cdb_valid_in && (rob.cdb_idx_in == rob.query_idx2_in);
  assign rob.query_ready1_out = done_q[rob.query_idx1_in] || cdbHit1;
  assign rob.query_ready2_out = done_q[rob.query_idx2_in] || cdbHit2;
  assign rob.query_data1_out  = cdbHit1 ? rob.cdb_data_in : value_q[rob.query_idx1_in];
  assign rob.query_data2_out  = cdbHit2 ? rob.cdb_data_in : value_q[rob.query_idx2_in];
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default build, ROB_BYPASS_EN undefined).
module tb_reorder_buffer;
  localparam int SIZE  = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   nCompared   = 0;
  int   nMismatched = 0;

  reorder_buffer_if #(.SIZE(SIZE)) robIf ();

  reorder_buffer #(.SIZE(SIZE)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rob    (robIf.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    robIf.alloc_valid_in    = 1'b0;
    robIf.alloc_rd_in       = 5'd0;
    robIf.alloc_has_rd_in   = 1'b0;
    robIf.cdb_valid_in      = 1'b0;
    robIf.cdb_idx_in        = '0;
    robIf.cdb_data_in       = '0;
    robIf.cdb_mispredict_in = 1'b0;
    robIf.cdb_target_in     = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic setAlloc(input logic [4:0] rd, input logic hasRd);
    robIf.alloc_valid_in  = 1'b1;
    robIf.alloc_rd_in     = rd;
    robIf.alloc_has_rd_in = hasRd;
  endtask

  task automatic setCdb(input logic [2:0] idx, input logic [31:0] data, input logic misp, input logic [31:0] tgt);
    robIf.cdb_valid_in      = 1'b1;
    robIf.cdb_idx_in        = idx;
    robIf.cdb_data_in       = data;
    robIf.cdb_mispredict_in = misp;
    robIf.cdb_target_in     = tgt;
  endtask

  task automatic test_reset();
    doReset();
    nCompared++; if (robIf.count_out !== 4'd0) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", robIf.count_out); end
    nCompared++; if (robIf.we_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_we: got %0b expected 0", robIf.we_out); end
    nCompared++; if (robIf.flush_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_flush: got %0b expected 0", robIf.flush_out); end
    nCompared++; if (robIf.flush_addrs_out !== '0) begin nMismatched++; $display("[TB] FAIL reset_flush_addrs: got %0h expected 0", robIf.flush_addrs_out); end
    nCompared++; if (robIf.redirect_pc_out !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_redirect: got %0h expected 0", robIf.redirect_pc_out); end
    nCompared++; if (robIf.ready_out !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready: got %0b expected 1", robIf.ready_out); end
    nCompared++; if (robIf.alloc_idx_out !== 3'd0) begin nMismatched++; $display("[TB] FAIL reset_alloc_idx: got %0d expected 0", robIf.alloc_idx_out); end
  endtask

  task automatic test_fill();
    doReset();
    for (int i = 0; i < SIZE; i++) begin
      setAlloc(5'(i + 1), 1'b1);
      #1;
      nCompared++; if (robIf.alloc_idx_out !== 3'(i)) begin nMismatched++; $display("[TB] FAIL fill_alloc_idx[%0d]: got %0d expected %0d", i, robIf.alloc_idx_out, i); end
      tick();
    end
    nCompared++; if (robIf.ready_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL fill_ready_full: got %0b expected 0", robIf.ready_out); end
    nCompared++; if (robIf.count_out !== 4'd8) begin nMismatched++; $display("[TB] FAIL fill_count: got %0d expected 8", robIf.count_out); end
    tick();
    idleInputs();
    nCompared++; if (robIf.count_out !== 4'd8) begin nMismatched++; $display("[TB] FAIL fill_ninth_dropped_count: got %0d expected 8", robIf.count_out); end
    nCompared++; if (robIf.alloc_idx_out !== 3'd0) begin nMismatched++; $display("[TB] FAIL fill_tail_wrapped: got %0d expected 0", robIf.alloc_idx_out); end
  endtask

  task automatic test_out_of_order();
    doReset();
    setAlloc(5'd1, 1'b1); tick();
    setAlloc(5'd2, 1'b1); tick();
    idleInputs();
    setCdb(3'd1, 32'd22, 1'b0, 32'd0); tick();
    nCompared++; if (robIf.we_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL ooo_no_early_commit: got %0b expected 0", robIf.we_out); end
    setCdb(3'd0, 32'd11, 1'b0, 32'd0); tick();
    nCompared++; if (robIf.we_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL ooo_commit_latency: got %0b expected 0", robIf.we_out); end
    idleInputs();
    setAlloc(5'd3, 1'b1); tick();
    idleInputs();
    nCompared++; if ({robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out} !== {1'b1, 5'd1, 32'd11, 3'd0}) begin nMismatched++;
      $display("[TB] FAIL ooo_first_retire: got we=%0b wa=%0d wd=%0d ix=%0d expected we=1 wa=1 wd=11 ix=0", robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out); end
    nCompared++; if (robIf.count_out !== 4'd2) begin nMismatched++; $display("[TB] FAIL ooo_alloc_commit_count: got %0d expected 2", robIf.count_out); end
    tick();
    nCompared++; if ({robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out} !== {1'b1, 5'd2, 32'd22, 3'd1}) begin nMismatched++;
      $display("[TB] FAIL ooo_second_retire: got we=%0b wa=%0d wd=%0d ix=%0d expected we=1 wa=2 wd=22 ix=1", robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out); end
    tick();
    nCompared++; if ({robIf.we_out, robIf.wa_out} !== {1'b0, 5'd2}) begin nMismatched++; $display("[TB] FAIL ooo_idle_hold: got we=%0b wa=%0d expected we=0 wa=2", robIf.we_out, robIf.wa_out); end
  endtask

  task automatic test_wrap();
    doReset();
    for (int i = 0; i < SIZE; i++) begin
      setAlloc(5'(i + 1), 1'b1); tick();
    end
    idleInputs();
    setCdb(3'd0, 32'd100, 1'b0, 32'd0); tick();
    setCdb(3'd1, 32'd101, 1'b0, 32'd0); tick();
    nCompared++; if ({robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out} !== {1'b1, 5'd1, 32'd100, 3'd0}) begin nMismatched++;
      $display("[TB] FAIL wrap_retire0: got we=%0b wa=%0d wd=%0d ix=%0d", robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out); end
    setCdb(3'd2, 32'd102, 1'b0, 32'd0); tick();
    idleInputs(); tick();
    nCompared++; if ({robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out} !== {5'd3, 32'd102, 3'd2}) begin nMismatched++;
      $display("[TB] FAIL wrap_retire2: got wa=%0d wd=%0d ix=%0d expected wa=3 wd=102 ix=2", robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out); end
    nCompared++; if (robIf.count_out !== 4'd5) begin nMismatched++; $display("[TB] FAIL wrap_count_after_retire: got %0d expected 5", robIf.count_out); end
    for (int i = 0; i < 3; i++) begin
      setAlloc(5'(i + 9), 1'b1);
      #1;
      nCompared++; if (robIf.alloc_idx_out !== 3'(i)) begin nMismatched++; $display("[TB] FAIL wrap_alloc_idx[%0d]: got %0d expected %0d", i, robIf.alloc_idx_out, i); end
      tick();
    end
    idleInputs();
    nCompared++; if (robIf.count_out !== 4'd8) begin nMismatched++; $display("[TB] FAIL wrap_count_refill: got %0d expected 8", robIf.count_out); end
    setCdb(3'd0, 32'd500, 1'b0, 32'd0); tick();
    nCompared++; if (robIf.we_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_young_not_retired: got %0b expected 0", robIf.we_out); end
    setCdb(3'd3, 32'd300, 1'b0, 32'd0); tick();
    idleInputs(); tick();
    nCompared++; if ({robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out} !== {1'b1, 5'd4, 32'd300, 3'd3}) begin nMismatched++;
      $display("[TB] FAIL wrap_retire3: got we=%0b wa=%0d wd=%0d ix=%0d expected we=1 wa=4 wd=300 ix=3", robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out); end
    tick();
    nCompared++; if (robIf.we_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_head4_waits: got %0b expected 0", robIf.we_out); end
  endtask

  task automatic test_no_rd();
    doReset();
    setAlloc(5'd0, 1'b1); tick();
    setAlloc(5'd7, 1'b0); tick();
    idleInputs();
    setCdb(3'd0, 32'd5, 1'b0, 32'd0); tick();
    setCdb(3'd1, 32'd6, 1'b0, 32'd0); tick();
    nCompared++; if ({robIf.we_out, robIf.wrob_ix_out, robIf.count_out} !== {1'b0, 3'd0, 4'd1}) begin nMismatched++;
      $display("[TB] FAIL nord_x0_retire: got we=%0b ix=%0d count=%0d expected we=0 ix=0 count=1", robIf.we_out, robIf.wrob_ix_out, robIf.count_out); end
    idleInputs(); tick();
    nCompared++; if ({robIf.we_out, robIf.wrob_ix_out, robIf.wa_out, robIf.wd_out, robIf.count_out} !== {1'b0, 3'd1, 5'd7, 32'd6, 4'd0}) begin nMismatched++;
      $display("[TB] FAIL nord_hasrd0_retire: got we=%0b ix=%0d wa=%0d wd=%0d count=%0d expected 0/1/7/6/0", robIf.we_out, robIf.wrob_ix_out, robIf.wa_out, robIf.wd_out, robIf.count_out); end
  endtask

  task automatic test_mispredict();
    logic [SIZE-1:0][4:0] expAddrs;
    expAddrs    = '0;
    expAddrs[1] = 5'd5;
    expAddrs[2] = 5'd6;
    doReset();
    setAlloc(5'd1, 1'b1); tick();
    setAlloc(5'd5, 1'b1); tick();
    setAlloc(5'd6, 1'b1); tick();
    idleInputs();
    setCdb(3'd0, 32'h1234, 1'b1, 32'h40); tick();
    idleInputs();
    setAlloc(5'd9, 1'b1);
    #1;
    nCompared++; if (robIf.ready_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL misp_ready_blocked: got %0b expected 0", robIf.ready_out); end
    tick();
    idleInputs();
    nCompared++; if ({robIf.flush_out, robIf.redirect_pc_out} !== {1'b1, 32'h40}) begin nMismatched++;
      $display("[TB] FAIL misp_flush: got flush=%0b pc=%0h expected flush=1 pc=40", robIf.flush_out, robIf.redirect_pc_out); end
    nCompared++; if (robIf.flush_addrs_out !== expAddrs) begin nMismatched++; $display("[TB] FAIL misp_flush_addrs: got %0h expected %0h", robIf.flush_addrs_out, expAddrs); end
    nCompared++; if (robIf.count_out !== 4'd0) begin nMismatched++; $display("[TB] FAIL misp_count: got %0d expected 0", robIf.count_out); end
    nCompared++; if ({robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out} !== {1'b1, 5'd1, 32'h1234, 3'd0}) begin nMismatched++;
      $display("[TB] FAIL misp_link_write: got we=%0b wa=%0d wd=%0h ix=%0d expected we=1 wa=1 wd=1234 ix=0", robIf.we_out, robIf.wa_out, robIf.wd_out, robIf.wrob_ix_out); end
    tick();
    nCompared++; if ({robIf.flush_out, robIf.we_out, robIf.count_out} !== {1'b0, 1'b0, 4'd0}) begin nMismatched++;
      $display("[TB] FAIL misp_single_pulse: got flush=%0b we=%0b count=%0d expected 0/0/0", robIf.flush_out, robIf.we_out, robIf.count_out); end
    nCompared++; if ({robIf.ready_out, robIf.alloc_idx_out} !== {1'b1, 3'd0}) begin nMismatched++;
      $display("[TB] FAIL misp_restart: got ready=%0b idx=%0d expected ready=1 idx=0", robIf.ready_out, robIf.alloc_idx_out); end
  endtask

  task automatic test_midreset();
    doReset();
    for (int i = 0; i < 4; i++) begin
      setAlloc(5'(i + 1), 1'b1); tick();
    end
    idleInputs();
    setCdb(3'd0, 32'd9, 1'b0, 32'd0); tick();
    rst = 1'b1;
    setCdb(3'd1, 32'd7, 1'b0, 32'd0);
    setAlloc(5'd12, 1'b1);
    tick();
    rst = 1'b0;
    idleInputs();
    #1;
    nCompared++; if ({robIf.count_out, robIf.we_out, robIf.alloc_idx_out, robIf.ready_out} !== {4'd0, 1'b0, 3'd0, 1'b1}) begin nMismatched++;
      $display("[TB] FAIL midreset_state: got count=%0d we=%0b idx=%0d ready=%0b expected 0/0/0/1", robIf.count_out, robIf.we_out, robIf.alloc_idx_out, robIf.ready_out); end
    tick();
    nCompared++; if ({robIf.we_out, robIf.count_out} !== {1'b0, 4'd0}) begin nMismatched++;
      $display("[TB] FAIL midreset_quiet: got we=%0b count=%0d expected 0/0", robIf.we_out, robIf.count_out); end
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_fill();
    test_out_of_order();
    test_wrap();
    test_no_rd();
    test_mispredict();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the Tomasulo core.
- Issue allocates an entry per dispatched instruction and hands its index to the reservation station as rob_idx.
- The CDB writes results back out of order.
- Head entries retire in order and drive the register file writeback and flush inputs (wa/we/wd/rob_ix, flush/flush_addrs).

Parameters:
SIZE, 8, entry count; power of two; index width IDX_W = $clog2(SIZE) = 3, matching register file rob_ix width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
alloc_valid_in  input  1  issue stage requests an entry
alloc_rd_in  input  5  destination register
alloc_has_rd_in  input  1  instruction writes rd
ready_out  output  1  entry available this cycle (combinational)
alloc_idx_out  output  IDX_W  index granted on this cycle's allocation (= tail, combinational)
cdb_valid_in  input  1  result broadcast valid
cdb_idx_in  input  IDX_W  ROB index of broadcast result
cdb_data_in  input  32  result value (signed)
cdb_mispredict_in  input  1  branch/jump resolved mispredicted
cdb_target_in  input  32  correct next PC for a mispredict
we_out  output  1  register file write enable
wa_out  output  5  register file write address
wd_out  output  32  register file write data
wrob_ix_out  output  IDX_W  index of retiring entry
flush_out  output  1  squash pulse
flush_addrs_out  output  5 x SIZE  rd of each squashed entry; 0 for unused slots
redirect_pc_out  output  32  PC to refetch on flush
count_out  output  IDX_W+1  occupied entries

Behaviour:
- Entry fields: busy, done, rd, has_rd, value, mispredict, target.
- Pointers: head, tail (IDX_W bits, wrap modulo SIZE); count (IDX_W+1 bits).
- Reset: all busy/done = 0, head = tail = count = 0.
  - Registered outputs return to 0: we_out, wa_out, wd_out, wrob_ix_out, flush_out, flush_addrs_out, redirect_pc_out.
- commit_ok = entry[head].busy && entry[head].done (pre-edge state).
- ready_out = (count < SIZE) && !(commit_ok && entry[head].mispredict).
- Allocate:
  - Condition: alloc_valid_in && ready_out.
  - Edge: entry[tail] <= {busy 1, done 0, rd, has_rd, mispredict 0}; tail <= tail + 1.
  - alloc_valid_in while ready_out = 0 is dropped; no state change.
- Writeback:
  - Condition: cdb_valid_in and entry[cdb_idx_in].busy.
  - Edge: done <= 1; value, mispredict, target captured.
  - Writeback to a non-busy entry is ignored.
- Commit (one per cycle, outputs registered, 1-cycle latency):
  - On a commit_ok edge: we_out <= has_rd && rd != 0; wa_out <= rd; wd_out <= value; wrob_ix_out <= head.
  - Also on that edge: busy[head] <= 0; head <= head + 1.
  - On non-commit edges: we_out <= 0 and flush_out <= 0; the other outputs hold.
  - has_rd = 0 or rd = x0 still retires, but with we_out = 0.
- Mispredict at commit:
  - Head retires normally; its link value is written.
  - Same edge: flush_out <= 1 (single cycle); redirect_pc_out <= target.
  - flush_addrs_out[i] <= rd for every other busy entry with has_rd, else 0.
  - All busy/done cleared; head = tail = count = 0.
- count next = count + alloc - commit, with flush taking priority.
  - Allocate and commit on the same edge leaves count unchanged.
- Simultaneous writeback and commit on the same entry: commit uses pre-edge done, so no hazard.
- rst_in mid-operation overrides every event in that cycle.

Optional Feature:
ROB_BYPASS_EN
- Defined: adds operand lookup ports for the issue stage.
  - query_idx1_in, query_idx2_in: inputs, IDX_W each.
  - query_ready1_out, query_ready2_out: outputs, 1 each; high if the entry is done, or cdb_valid_in with a matching cdb_idx_in this cycle.
  - query_data1_out, query_data2_out: outputs, 32 each; stored value, or cdb_data_in on a CDB match.
  - All lookup outputs are combinational.
- Undefined: these ports and their logic do not exist. The reservation station waits on CDB broadcast only.

Test Plan:
- Reset, then 8 allocs (rd 1..8) with no CDB -> alloc_idx_out 0..7, count_out 8, ready_out 0; 9th alloc dropped.
- Allocate idx 0, 1; CDB idx 1 data 22, then idx 0 data 11 -> we_out pulses wa 1 wd 11 ix 0, then wa 2 wd 22 ix 1, in order.
- Fill 8 entries, retire 3, allocate 3 -> tail wraps to 3, alloc_idx_out 0, 1, 2; retire order intact.
- Allocate rd 0 and has_rd 0 entries, then complete them -> both retire, count drops, we_out stays 0.
- Allocate idx 0 (rd 1, branch), idx 1 (rd 5), idx 2 (rd 6); CDB idx 0 mispredict target 0x40 -> ready_out 0 during commit cycle.
  - Next cycle: flush_out 1 for one cycle, redirect_pc_out 0x40, flush_addrs_out[1] = 5, flush_addrs_out[2] = 6, others 0, count_out 0.
- Assert rst_in while 4 entries are busy and cdb_valid_in is high -> count_out 0, we_out 0, next alloc_idx_out 0.
